// File: rtl/or4_sweep_gen_if.sv
// or4_sweep_gen_if: groups the sweep control/status handshake and the gate-side
// vector/response signals of the or4 truth-table sweeper.
//   start      : sweep request (master -> slave)
//   z0         : or4 gate output fed back (master -> slave)
//   x0..x3     : gate inputs, x0 = MSB of vector index (slave -> master)
//   busy, done : sweep status (slave -> master)
//   err_cnt    : mismatching vector count 0..16 (slave -> master)
//   first_fail : index of first mismatching vector (slave -> master)
//   pass       : done && err_cnt == 0 (slave -> master)
interface or4_sweep_gen_if;
    logic       start;
    logic       z0;
    logic       x0;
    logic       x1;
    logic       x2;
    logic       x3;
    logic       busy;
    logic       done;
    logic [4:0] err_cnt;
    logic [3:0] first_fail;
    logic       pass;

    modport master (
        output start,
        output z0,
        input  x0,
        input  x1,
        input  x2,
        input  x3,
        input  busy,
        input  done,
        input  err_cnt,
        input  first_fail,
        input  pass
    );

    modport slave (
        input  start,
        input  z0,
        output x0,
        output x1,
        output x2,
        output x3,
        output busy,
        output done,
        output err_cnt,
        output first_fail,
        output pass
    );
endinterface

// File: rtl/or4_sweep_gen.sv
// or4_sweep_gen: drives the four or4 inputs through all 16 combinations, holding
// each vector HOLD cycles, and checks the returned z0 against the expected OR.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : or4_sweep_gen_if.slave (start, z0 in; x0..x3, busy, done,
//          err_cnt, first_fail, pass out)
// Parameter HOLD (2..65535): cycles each vector is held.
// Build option: define OR4_SWEEP_CHECK_EN to include the z0 checker; without it
// the block is a pure pattern generator and err_cnt/first_fail/pass are 0.
module or4_sweep_gen #(
    parameter int unsigned HOLD = 20
) (
    input  logic           clk,
    input  logic           rst,
    or4_sweep_gen_if.slave bus
);
    localparam int unsigned HW = $clog2(HOLD);
    localparam int unsigned VW = 4;
    localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);
    localparam logic [VW-1:0] V_LAST = VW'(15);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] vec_q, vec_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          go_c;
    logic          sample_c;

    // Start is honoured only when no sweep is running.
    assign go_c     = bus.start && ((state_q == IDLE) || (state_q == DONE));
    // Last edge of a vector window: z0 is compared and the vector advances.
    assign sample_c = (state_q == DRIVE) && (h_q == H_LAST);

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            h_q     <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            h_q     <= h_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        h_d     = h_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (go_c) begin
                    state_d = DRIVE;
                    v_d     = '0;
                    h_d     = '0;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            DRIVE: begin
                h_d = h_q + HW'(1);
                if (sample_c) begin
                    h_d = '0;
                    v_d = v_q + VW'(1);
                    if (v_q == V_LAST) begin
                        state_d = DONE;
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Output register tracks the next index so x* changes
                        // exactly at the window boundary.
                        vec_d = v_q + VW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                v_d     = '0;
                h_d     = '0;
                vec_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign bus.x0   = vec_q[3];
    assign bus.x1   = vec_q[2];
    assign bus.x2   = vec_q[1];
    assign bus.x3   = vec_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef OR4_SWEEP_CHECK_EN
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] CNT_MAX = CW'(16);

    logic [CW-1:0] err_q, err_d;
    logic [VW-1:0] ff_q, ff_d;
    logic          mismatch_c;

    // Expected OR output is 1 for every vector except 0000.
    assign mismatch_c = bus.z0 != (v_q != '0);

    // Checker registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            ff_q  <= '0;
        end else begin
            err_q <= err_d;
            ff_q  <= ff_d;
        end
    end

    // Checker update: clear on accepted start, count on sampling edges
    always_comb begin
        err_d = err_q;
        ff_d  = ff_q;
        if (go_c) begin
            err_d = '0;
            ff_d  = '0;
        end else if (sample_c && mismatch_c) begin
            if (err_q == '0) begin
                ff_d = v_q;
            end
            if (err_q != CNT_MAX) begin
                err_d = err_q + CW'(1);
            end
        end
    end

    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;
    assign bus.pass       = done_q && (err_q == '0);
`else
    logic unused_z0;
    assign unused_z0      = bus.z0;
    assign bus.err_cnt    = '0;
    assign bus.first_fail = '0;
    assign bus.pass       = 1'b0;
`endif

endmodule

// File: tb/tb_or4_sweep_gen.sv
// tb_or4_sweep_gen: scoreboard bench for or4_sweep_gen with HOLD = 4.
// The stimulus process pushes the hand-computed sweep result when it issues a
// start; a negedge monitor checks x* every busy cycle and pops/compares the
// expected result on each rising edge of done.
module tb_or4_sweep_gen;
    localparam int unsigned HOLD = 4;
    localparam int unsigned SWEEP = 16 * HOLD;

    typedef struct {
        int err;
        int ff;
        int pass;
    } exp_t;

    logic clk;
    logic rst;
    int   mode;      // 0 = correct or4, 1 = z0 stuck at 0, 2 = z0 stuck at 1
    int   checks;
    int   errors;
    exp_t sb[$];

    or4_sweep_gen_if bus ();

    or4_sweep_gen #(.HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model on the board side
    always_comb begin
        case (mode)
            1:       bus.z0 = 1'b0;
            2:       bus.z0 = 1'b1;
            default: bus.z0 = bus.x0 | bus.x1 | bus.x2 | bus.x3;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected sweep outcome for the active gate mode
    function automatic exp_t expect_for(input int m);
        exp_t e;
`ifdef OR4_SWEEP_CHECK_EN
        case (m)
            1:       begin e.err = 15; e.ff = 1; e.pass = 0; end
            2:       begin e.err = 1;  e.ff = 0; e.pass = 0; end
            default: begin e.err = 0;  e.ff = 0; e.pass = 1; end
        endcase
`else
        e.err = 0; e.ff = 0; e.pass = 0;
        if (m < 0) e.err = 0;
`endif
        return e;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=%0b after %0d cycles", bus.done, n);
        end
    endtask

    // Monitor: vector sequence while busy, result check on done rising
    int   busy_cnt;
    logic prev_done;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy) begin
                chk("x_vec", 32'({bus.x0, bus.x1, bus.x2, bus.x3}), 32'(busy_cnt / HOLD));
                busy_cnt++;
            end
            if (bus.done && !prev_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: done rose with no expected result");
                end else begin
                    e = sb.pop_front();
                    chk("busy_len",   32'(busy_cnt), 32'(SWEEP));
                    chk("err_cnt",    32'(bus.err_cnt), 32'(e.err));
                    chk("first_fail", 32'(bus.first_fail), 32'(e.ff));
                    chk("pass",       32'(bus.pass), 32'(e.pass));
                    chk("x_at_done",  32'({bus.x0, bus.x1, bus.x2, bus.x3}), 32'd0);
                end
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        mode      = 0;
        busy_cnt  = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_x",     32'({bus.x0, bus.x1, bus.x2, bus.x3}), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_err",   32'(bus.err_cnt), 32'd0);
        chk("rst_ff",    32'(bus.first_fail), 32'd0);
        chk("rst_pass",  32'(bus.pass), 32'd0);
        cyc();

        // Clean sweep with a correct gate
        mode = 0;
        sb.push_back(expect_for(0));
        pulse_start();
        chk("busy_rise", 32'(bus.busy), 32'd1);
        wait_done(SWEEP + 8);

        // done holds while start stays low
        repeat (10) cyc();
        chk("done_hold", 32'(bus.done), 32'd1);
        chk("busy_hold", 32'(bus.busy), 32'd0);

        // Restart from DONE with z0 stuck at 0
        mode = 1;
        sb.push_back(expect_for(1));
        pulse_start();
        chk("restart_done", 32'(bus.done), 32'd0);
        chk("restart_err",  32'(bus.err_cnt), 32'd0);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        wait_done(SWEEP + 8);
        cyc();

        // z0 stuck at 1
        mode = 2;
        sb.push_back(expect_for(2));
        pulse_start();
        wait_done(SWEEP + 8);
        cyc();

        // Reset in the middle of a sweep
        mode = 0;
        pulse_start();
        repeat (29) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_x",    32'({bus.x0, bus.x1, bus.x2, bus.x3}), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_err",  32'(bus.err_cnt), 32'd0);
        chk("midrst_ff",   32'(bus.first_fail), 32'd0);
        cyc();
        chk("midrst_idle", 32'(bus.busy), 32'd0);

        // start re-pulsed during DRIVE is ignored
        sb.push_back(expect_for(0));
        pulse_start();
        repeat (9) cyc();
        pulse_start();
        chk("ignored_busy", 32'(bus.busy), 32'd1);
        wait_done(SWEEP + 8);

        repeat (3) cyc();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
